// File: rtl/instruction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_pkg
// Description : Opcode/funct3 constants, decoded-op enum, FSM state enum and
//               instruction field/immediate extraction helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADDI = 2'd1,
        OP_BNE  = 2'd2,
        OP_LUI  = 2'd3
    } op_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    function automatic logic [6:0] f_opcode(input logic [31:0] inst);
        return inst[6:0];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [2:0] f_funct3(input logic [31:0] inst);
        return inst[14:12];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    // I-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // B-type immediate (byte offset, bit 0 always zero), sign-extended
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // U-type immediate, upper 20 bits in place
    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'h000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : decode_scoreboard
// Description : Register busy vector. Set on issue, cleared on writeback or
//               when the owning instruction is flushed. x0 is never busy.
//               Queries see a same-cycle writeback clear as not busy.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_scoreboard #(
    parameter int NREG = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       set_en,
    input  logic [4:0] set_rd,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    input  logic       flush_en,
    input  logic [4:0] flush_rd,
    input  logic [4:0] rs1_idx,
    input  logic [4:0] rs2_idx,
    input  logic [4:0] rd_idx,
    output logic       rs1_busy,
    output logic       rs2_busy,
    output logic       rd_busy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] flush_mask;
    logic [NREG-1:0] live;

    assign set_mask   = set_en   ? (NREG'(1) << set_rd)   : '0;
    assign wb_mask    = wb_valid ? (NREG'(1) << wb_rd)    : '0;
    assign flush_mask = flush_en ? (NREG'(1) << flush_rd) : '0;

    // Busy bits as seen this cycle, with any writeback already applied
    assign live = busy & ~wb_mask;

    assign rs1_busy = live[rs1_idx];
    assign rs2_busy = live[rs2_idx];
    assign rd_busy  = live[rd_idx];

    // Clears first, then set so a same-cycle issue keeps its register busy; bit 0 forced low
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~wb_mask & ~flush_mask) | set_mask) & ~NREG'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Single-issue decode for ADDI/BNE/LUI with valid/ready in and
//               out, immediate generation, busy scoreboard hazard stall and
//               flush from execute.
//               Optional feature macro: DECODE_ILLEGAL_TRAP_EN - flag illegal
//               encodings and halt once one is handed to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import instruction_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [1:0]      id_op,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [4:0]      id_rd,
    output logic            id_rd_we,
    output logic [XLEN-1:0] id_imm,
    output logic            id_illegal,
    input  logic            ex_flush,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    op_t             op;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            rd_we;
    logic            use_rs1;
    logic            use_rs2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;
    logic            hazard;
    logic            run;
    logic            transfer;

    assign opcode = f_opcode(if_inst);
    assign funct3 = f_funct3(if_inst);
    assign rs1    = f_rs1(if_inst);
    assign rs2    = f_rs2(if_inst);
    assign rd     = f_rd(if_inst);

    // Decode the offered instruction; anything unrecognised falls out as a NOP
    always_comb begin
        op      = OP_NOP;
        imm32   = '0;
        rd_we   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (opcode == OPC_OPIMM && funct3 == F3_ADDI) begin
            op      = OP_ADDI;
            imm32   = imm_i(if_inst);
            rd_we   = (rd != 5'd0);
            use_rs1 = 1'b1;
        end else if (opcode == OPC_BRANCH && funct3 == F3_BNE) begin
            op      = OP_BNE;
            imm32   = imm_b(if_inst);
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
        end else if (opcode == OPC_LUI) begin
            op      = OP_LUI;
            imm32   = imm_u(if_inst);
            rd_we   = (rd != 5'd0);
        end
    end

    assign imm = XLEN'($signed(imm32));

    assign hazard   = (use_rs1 & rs1_busy) | (use_rs2 & rs2_busy) | (rd_we & rd_busy);
    assign if_ready = run & ~ex_flush & ~hazard & (~id_valid | id_ready);
    assign transfer = if_valid & if_ready;

    decode_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (transfer & rd_we),
        .set_rd   (rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .flush_en (ex_flush & id_valid & id_rd_we),
        .flush_rd (id_rd),
        .rs1_idx  (rs1),
        .rs2_idx  (rs2),
        .rd_idx   (rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic   illegal;
    state_t state;
    state_t state_next;

    assign illegal = (op == OP_NOP);
    assign run     = (state == ST_RUN);

    // Halt state register; only reset brings the stage back to RUN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Enter HALT once a flagged entry is actually handed to execute
    always_comb begin
        state_next = state;
        if (state == ST_RUN && id_valid && id_ready && !ex_flush && id_illegal) begin
            state_next = ST_HALT;
        end
    end

    // Illegal flag travels alongside the rest of the output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_illegal <= 1'b0;
        end else if (!ex_flush && transfer) begin
            id_illegal <= illegal;
        end
    end
`else
    assign run        = 1'b1;
    assign id_illegal = 1'b0;
`endif

    // Output pipeline register: flush kills, transfer loads, handoff empties
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_op    <= OP_NOP;
            id_rs1   <= '0;
            id_rs2   <= '0;
            id_rd    <= '0;
            id_rd_we <= 1'b0;
            id_imm   <= '0;
        end else if (ex_flush) begin
            id_valid <= 1'b0;
        end else if (transfer) begin
            id_valid <= 1'b1;
            id_pc    <= if_pc;
            id_op    <= op;
            id_rs1   <= rs1;
            id_rs2   <= rs2;
            id_rd    <= rd;
            id_rd_we <= rd_we;
            id_imm   <= imm;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Single-issue instruction decode stage between instruction fetch and execute. Accepts one fetched instruction per cycle over a valid/ready handshake, decodes the supported subset (ADDI, BNE, LUI), generates sign-extended immediates, and holds the result in an output pipeline register toward execute. A register busy scoreboard stalls RAW/WAW hazards until writeback. A branch flush from execute kills the instruction held in decode.

## Interface
Parameters:
- XLEN, 32, datapath and PC width.
- NREG, 32, architectural register count; x0 is never busy.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- if_valid  in  1  fetch offers an instruction.
- if_ready  out  1  decode accepts this cycle.
- if_pc  in  XLEN  PC of offered instruction.
- if_inst  in  32  instruction word.
- id_valid  out  1  decoded instruction is valid.
- id_ready  in  1  execute accepts this cycle.
- id_pc  out  XLEN  PC of the decoded instruction.
- id_op  out  2  op_t: OP_NOP, OP_ADDI, OP_BNE, OP_LUI.
- id_rs1, id_rs2, id_rd  out  5  register indices.
- id_rd_we  out  1  instruction writes rd (forced 0 when rd == 0).
- id_imm  out  XLEN  sign-extended immediate.
- id_illegal  out  1  unsupported encoding (see Configuration).
- ex_flush  in  1  branch redirect; kills decode contents.
- wb_valid  in  1  writeback this cycle.
- wb_rd  in  5  register written back; clears its busy bit.

## Operation
- Decode: inst[1:0] must be 2'b11. OPIMM + funct3 ADDI -> OP_ADDI (I-imm = sext(inst[31:20]), rd_we=1). BRANCH + funct3 BNE -> OP_BNE (B-imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}), rd_we=0, reads rs1 and rs2). LUI -> OP_LUI (imm = {inst[31:12],12'b0}, rd_we=1, reads nothing). Anything else is illegal.
- Sources used: ADDI uses rs1; BNE uses rs1 and rs2; LUI uses none. Unused sources never cause hazards.
- Hazard: a used source is busy, or rd_we and rd is busy. A busy bit being cleared by wb in the same cycle counts as not busy.
- if_ready = state==RUN & ~ex_flush & ~hazard & (~id_valid | id_ready).
- Transfer (if_valid & if_ready): load the output register and set busy[rd] if rd_we. If a set and a wb clear hit the same register in one cycle, the set wins.
- Output handoff: id_valid & id_ready with no new transfer -> id_valid 0. Outputs hold stable while id_valid & ~id_ready.
- Flush: ex_flush -> id_valid 0 next cycle and clear busy[id_rd] if the killed entry had id_rd_we. Flush beats id_ready and any wb. No transfer occurs in a flush cycle. The WAW stall guarantees no older writer shares that rd.
- FSM: RUN, HALT. RUN->HALT when an illegal instruction is handed to execute (macro only). HALT is left only by reset.

## Timing
- Latency: 1 cycle from the input handshake to id_valid.
- Throughput: 1 instruction per cycle with no hazard and id_ready high.
- Reset (reset_n low at the clk edge): id_valid 0, id_pc/id_imm 0, id_op OP_NOP, id_rs1/rs2/rd 0, id_rd_we 0, id_illegal 0, all busy bits 0, state RUN. Reset mid-stall discards the held instruction.
- if_ready is combinational from the handshake inputs, the scoreboard, and ex_flush. There is no combinational path from if_valid to if_ready.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: illegal encodings produce id_op OP_NOP, id_rd_we 0, and id_illegal 1 with id_valid. Once that entry is handed to execute, the FSM enters HALT and if_ready stays 0.
- Not defined: illegal encodings decode silently as OP_NOP, id_illegal is tied 0, and no HALT state is built.

## Structure
- instruction_pkg gains: op_t enum, the funct3 constants in use, and the instruction-format field slices.
- Sub-module decode_scoreboard holds the NREG busy vector with set, clear-on-writeback, clear-on-flush, and busy query ports for rs1, rs2 and rd. The x0 bit is hardwired 0.

## Test plan
- ADDI x1,x0,5 (0x00500093) -> next cycle id_op OP_ADDI, id_rd 1, id_rs1 0, id_imm 5, id_rd_we 1, busy[1] 1.
- ADDI x2,x1,1 (0x00108113) offered while x1 is busy -> if_ready 0. Pulse wb_valid with wb_rd 1 -> accepted in that same cycle.
- BNE x1,x2,-8 (0xFE209CE3) -> id_op OP_BNE, id_imm 0xFFFFFFF8, id_rd_we 0. Also hold id_ready 0 for 3 cycles -> outputs stable and if_ready 0.
- LUI x3,0x12345 (0x123451B7) -> id_imm 0x12345000, id_rd 3.
- ADDI to x4 in the output register with ex_flush 1 and id_ready 1 -> id_valid 0 next cycle, busy[4] 0, no new transfer.
- 0x00000000 -> with the macro: id_illegal 1, if_ready 0 thereafter until reset. Without the macro: OP_NOP and normal flow.
